// File: rtl/ad9467_adc_if_pkg.sv
// Shared types and constants for the AD9467 ADC interface.
// FSM states, frame lengths, chip-select codes and small helpers.
package ad9467_adc_if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    localparam int CFG_FRAME_LEN    = 24;
    localparam int SAMPLE_FRAME_LEN = 16;
    localparam int FRAME_W          = 24;
    localparam int LEN_W            = 5;

    localparam logic [1:0] CS_NONE = 2'b11;
    localparam logic [1:0] CS_ADC  = 2'b10;
    localparam logic [1:0] CS_SINK = 2'b01;

    // Pin k carries bit 2k+1 on the rising edge and 2k on the falling edge.
    function automatic logic [15:0] ddr_merge(
        input logic [7:0] rise,
        input logic [7:0] fall
    );
        logic [15:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            w[2*k+1] = rise[k];
            w[2*k]   = fall[k];
        end
        return w;
    endfunction

    // AD9467 write instruction: R/W=0, W1:W0=00 (one byte), address, data.
    function automatic logic [FRAME_W-1:0] cfg_word(
        input logic [12:0] addr,
        input logic [7:0]  data
    );
        return {1'b0, 2'b00, addr, data};
    endfunction

endpackage

// File: rtl/ad9467_spi_master.sv
// Mode-0 SPI shifter and clock generator with parallel load.
// Ports: clk, rst_n (async active-low), load, data (MSB-aligned), len,
// miso in; sclk, mosi, done (1-cycle pulse), rx_data out.
module ad9467_spi_master
    import ad9467_adc_if_pkg::*;
#(
    parameter int SPI_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [FRAME_W-1:0] data,
    input  logic [LEN_W-1:0]   len,
    input  logic               miso,
    output logic               sclk,
    output logic               mosi,
    output logic               done,
    output logic [FRAME_W-1:0] rx_data
);

    localparam logic [7:0] DIV_LAST = 8'(SPI_DIV - 1);

    logic [7:0]         div_cnt;
    logic [FRAME_W-1:0] sr;
    logic [FRAME_W-1:0] rx;
    logic [LEN_W-1:0]   bits_left;
    logic               busy;
    logic               sclk_q;
    logic               done_q;
    logic               tick;

    assign tick = busy && (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            sr        <= '0;
            rx        <= '0;
            bits_left <= '0;
            busy      <= 1'b0;
            sclk_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                sr        <= data;
                bits_left <= len;
                busy      <= (len != '0);
                div_cnt   <= '0;
                sclk_q    <= 1'b0;
            end else if (busy) begin
                if (tick) begin
                    div_cnt <= '0;
                    sclk_q  <= ~sclk_q;
                    if (!sclk_q) begin
                        rx <= {rx[FRAME_W-2:0], miso};
                    end else begin
                        // Falling edge: advance to the next bit.
                        sr        <= {sr[FRAME_W-2:0], 1'b0};
                        bits_left <= bits_left - LEN_W'(1);
                        if (bits_left == LEN_W'(1)) begin
                            busy   <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
            end
        end
    end

    assign sclk    = sclk_q;
    assign mosi    = sr[FRAME_W-1];
    assign done    = done_q;
    assign rx_data = rx;

endmodule

// File: rtl/ad9467_adc_if.sv
// AD9467 DDR capture plus SPI config/sample frame sender.
// Ports: adc_clk_in_p, RESET (async low), adc_data_in_p[7:0], triggers,
// spi_miso in; data_reg_check[15:0], spi_clk/mosi/csn[1:0], TX_DV_check
// out. DATA_STORE_OUT_EN adds data_store_reg[15:0].
module ad9467_adc_if
    import ad9467_adc_if_pkg::*;
#(
    parameter int          SPI_DIV  = 4,
    parameter logic [12:0] CFG_ADDR = 13'h014,
    parameter logic [7:0]  CFG_DATA = 8'h00
) (
    input  logic        adc_clk_in_p,
    input  logic        RESET,
    input  logic [7:0]  adc_data_in_p,
    output logic [15:0] data_reg_check,
`ifdef DATA_STORE_OUT_EN
    output logic [15:0] data_store_reg,
`endif
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    input  logic        spi_send_trigger,
    input  logic        AD9467_spi_trigger,
    output logic        TX_DV_check,
    output logic [1:0]  spi_csn
);

    localparam logic [8:0] HOLD_LAST = 9'(2 * SPI_DIV - 1);

    logic [7:0] rise_q;
    logic [7:0] fall_q;

    always_ff @(posedge adc_clk_in_p or negedge RESET) begin
        if (!RESET) begin
            rise_q         <= '0;
            data_reg_check <= '0;
        end else begin
            rise_q         <= adc_data_in_p;
            data_reg_check <= ddr_merge(rise_q, fall_q);
        end
    end

    always_ff @(negedge adc_clk_in_p or negedge RESET) begin
        if (!RESET) begin
            fall_q <= '0;
        end else begin
            fall_q <= adc_data_in_p;
        end
    end

    // The arm flags stop a trigger held high through reset from firing.
    logic cfg_q;
    logic smp_q;
    logic cfg_arm;
    logic smp_arm;
    logic cfg_edge;
    logic smp_edge;

    always_ff @(posedge adc_clk_in_p or negedge RESET) begin
        if (!RESET) begin
            cfg_q   <= 1'b0;
            smp_q   <= 1'b0;
            cfg_arm <= 1'b0;
            smp_arm <= 1'b0;
        end else begin
            cfg_q   <= AD9467_spi_trigger;
            smp_q   <= spi_send_trigger;
            cfg_arm <= cfg_arm | ~AD9467_spi_trigger;
            smp_arm <= smp_arm | ~spi_send_trigger;
        end
    end

    assign cfg_edge = AD9467_spi_trigger & ~cfg_q & cfg_arm;
    assign smp_edge = spi_send_trigger & ~smp_q & smp_arm;

    state_t             state;
    state_t             state_nx;
    logic               is_cfg;
    logic               is_cfg_nx;
    logic [8:0]         hold_cnt;
    logic               spi_load;
    logic               spi_done;
    logic [FRAME_W-1:0] frame_data;
    logic [LEN_W-1:0]   frame_len;
    logic [FRAME_W-1:0] spi_rx_unused;

    always_ff @(posedge adc_clk_in_p or negedge RESET) begin
        if (!RESET) begin
            state  <= ST_IDLE;
            is_cfg <= 1'b0;
        end else begin
            state  <= state_nx;
            is_cfg <= is_cfg_nx;
        end
    end

    always_ff @(posedge adc_clk_in_p or negedge RESET) begin
        if (!RESET) begin
            hold_cnt <= '0;
        end else if (state == ST_DONE) begin
            hold_cnt <= hold_cnt + 9'd1;
        end else begin
            hold_cnt <= '0;
        end
    end

    always_comb begin
        state_nx    = state;
        is_cfg_nx   = is_cfg;
        spi_load    = 1'b0;
        TX_DV_check = 1'b0;
        spi_csn     = CS_NONE;
        unique case (state)
            ST_IDLE: begin
                // Config wins when both edges land together.
                if (cfg_edge) begin
                    is_cfg_nx = 1'b1;
                    state_nx  = ST_LOAD;
                end else if (smp_edge) begin
                    is_cfg_nx = 1'b0;
                    state_nx  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                TX_DV_check = 1'b1;
                spi_load    = 1'b1;
                state_nx    = ST_SHIFT;
            end
            ST_SHIFT: begin
                spi_csn = is_cfg ? CS_ADC : CS_SINK;
                if (spi_done) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign frame_data = is_cfg ? cfg_word(CFG_ADDR, CFG_DATA)
                               : {data_reg_check, 8'h00};
    assign frame_len  = is_cfg ? LEN_W'(CFG_FRAME_LEN)
                               : LEN_W'(SAMPLE_FRAME_LEN);

`ifdef DATA_STORE_OUT_EN
    always_ff @(posedge adc_clk_in_p or negedge RESET) begin
        if (!RESET) begin
            data_store_reg <= '0;
        end else if (state == ST_LOAD && !is_cfg) begin
            data_store_reg <= data_reg_check;
        end
    end
`endif

    ad9467_spi_master #(
        .SPI_DIV (SPI_DIV)
    ) u_spi (
        .clk     (adc_clk_in_p),
        .rst_n   (RESET),
        .load    (spi_load),
        .data    (frame_data),
        .len     (frame_len),
        .miso    (spi_miso),
        .sclk    (spi_clk),
        .mosi    (spi_mosi),
        .done    (spi_done),
        .rx_data (spi_rx_unused)
    );

endmodule

// File: tb/tb_ad9467_adc_if.sv
// Self-checking bench for ad9467_adc_if: DDR capture and SPI frames.
// Frames are reconstructed from the pins and compared to a model.
module tb_ad9467_adc_if;

    logic        clk = 1'b0;
    logic        RESET;
    logic [7:0]  adc;
    logic [15:0] dut_data;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso;
    logic        smp_t;
    logic        cfg_t;
    logic        tx_dv;
    logic [1:0]  spi_csn;
`ifdef DATA_STORE_OUT_EN
    logic [15:0] store;
`endif

    always #5 clk = ~clk;

    ad9467_adc_if dut (
        .adc_clk_in_p       (clk),
        .RESET              (RESET),
        .adc_data_in_p      (adc),
        .data_reg_check     (dut_data),
`ifdef DATA_STORE_OUT_EN
        .data_store_reg     (store),
`endif
        .spi_clk            (spi_clk),
        .spi_mosi           (spi_mosi),
        .spi_miso           (spi_miso),
        .spi_send_trigger   (smp_t),
        .AD9467_spi_trigger (cfg_t),
        .TX_DV_check        (tx_dv),
        .spi_csn            (spi_csn)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: bit 2k+1 = rising-edge level of pin k, bit 2k = falling.
    function automatic logic [15:0] model_ddr(input logic [7:0] r,
                                              input logic [7:0] f);
        int acc;
        acc = 0;
        for (int k = 0; k < 8; k++)
            acc += int'(r[k]) * 2 * (4 ** k) + int'(f[k]) * (4 ** k);
        return 16'(acc);
    endfunction

    // ---------------- frame monitor ----------------
    typedef struct {
        logic [1:0]  cs;
        int          nbits;
        logic [23:0] bits;
        bit          cs_stable;
    } frame_t;

    frame_t      frames[$];
    int          tot_edges = 0;
    int          stray_clk = 0;
    int          dv_count  = 0;
    logic [23:0] shreg     = '0;
    bit          in_frame  = 0;
    int          start_edges;
    logic [1:0]  cur_cs;
    bit          cur_ok;

    always @(posedge spi_clk) begin
        tot_edges++;
        shreg = {shreg[22:0], spi_mosi};
        if (spi_csn == 2'b11) stray_clk++;
    end

    always @(negedge clk) begin
        frame_t fr;
        if (tx_dv) dv_count++;
        if (!in_frame && spi_csn != 2'b11) begin
            in_frame    = 1;
            cur_cs      = spi_csn;
            cur_ok      = 1;
            start_edges = tot_edges;
        end else if (in_frame && spi_csn == 2'b11) begin
            in_frame     = 0;
            fr.cs        = cur_cs;
            fr.nbits     = tot_edges - start_edges;
            fr.bits      = shreg;
            fr.cs_stable = cur_ok;
            frames.push_back(fr);
        end else if (in_frame && spi_csn != cur_cs) begin
            cur_ok = 0;
        end
    end

    task automatic wait_frames(input string name, input int n,
                               input int budget);
        int c;
        c = 0;
        while (frames.size() < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        check(name, frames.size(), n);
    endtask

    task automatic pulse(input bit c, input bit s);
        @(posedge clk); #1;
        cfg_t = c;
        smp_t = s;
        repeat (3) @(posedge clk);
        #1;
        cfg_t = 0;
        smp_t = 0;
    endtask

    task automatic hold_adc(input logic [7:0] v);
        @(negedge clk); #1;
        adc = v;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic sample_frame(input string name, input logic [7:0] v);
        int dv0;
        hold_adc(v);
        frames.delete();
        dv0 = dv_count;
        pulse(0, 1);
        wait_frames({name, "_cnt"}, 1, 1000);
        if (frames.size() >= 1) begin
            check({name, "_cs"}, frames[0].cs, 2'b01);
            check({name, "_n"}, frames[0].nbits, 16);
            check({name, "_mosi"}, frames[0].bits[15:0], model_ddr(v, v));
            check({name, "_csst"}, frames[0].cs_stable, 1);
        end
        check({name, "_dv"}, dv_count - dv0, 1);
`ifdef DATA_STORE_OUT_EN
        check({name, "_store"}, store, model_ddr(v, v));
`endif
        repeat (20) @(posedge clk);
    endtask

    typedef struct {
        logic [7:0]  pin;
        logic [15:0] exp;
    } vec_t;

    vec_t       tbl[8];
    logic [7:0] rr[21];
    logic [7:0] ff[21];
    int         dv0;

    initial begin
        tbl[0] = '{8'hAA, 16'hCCCC};
        tbl[1] = '{8'h55, 16'h3333};
        tbl[2] = '{8'hFF, 16'hFFFF};
        tbl[3] = '{8'h00, 16'h0000};
        tbl[4] = '{8'h0F, 16'h00FF};
        tbl[5] = '{8'hF0, 16'hFF00};
        tbl[6] = '{8'h01, 16'h0003};
        tbl[7] = '{8'h80, 16'hC000};

        RESET    = 0;
        adc      = 8'h00;
        spi_miso = 0;
        smp_t    = 0;
        cfg_t    = 0;

        #2;
        check("rst_data", dut_data, 16'h0000);
        check("rst_csn", spi_csn, 2'b11);
        check("rst_sclk", spi_clk, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_txdv", tx_dv, 0);
`ifdef DATA_STORE_OUT_EN
        check("rst_store", store, 16'h0000);
`endif
        #8;
        RESET = 1;
        repeat (20) @(posedge clk);
        check("idle_no_frame", frames.size(), 0);

        for (int i = 0; i < 8; i++) begin
            hold_adc(tbl[i].pin);
            check("ddr_table", dut_data, tbl[i].exp);
        end

        for (int i = 0; i < 21; i++) begin
            rr[i] = 8'($urandom);
            ff[i] = 8'($urandom);
        end
        @(negedge clk); #1;
        adc = rr[0];
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i > 0) check("ddr_rand", dut_data, model_ddr(rr[i-1], ff[i-1]));
            adc = ff[i];
            @(negedge clk); #1;
            adc = rr[i+1];
        end
        hold_adc(8'hAA);

        frames.delete();
        dv0 = dv_count;
        pulse(1, 0);
        wait_frames("cfg_cnt", 1, 1000);
        if (frames.size() >= 1) begin
            check("cfg_cs", frames[0].cs, 2'b10);
            check("cfg_n", frames[0].nbits, 24);
            check("cfg_mosi", frames[0].bits, 24'h001400);
            check("cfg_csst", frames[0].cs_stable, 1);
        end
        check("cfg_dv", dv_count - dv0, 1);
        repeat (20) @(posedge clk);

        sample_frame("smp_cc", 8'hAA);
        for (int i = 0; i < 3; i++) sample_frame("smp_rand", 8'($urandom));

        frames.delete();
        dv0 = dv_count;
        @(posedge clk); #1;
        cfg_t = 1;
        smp_t = 1;
        repeat (50) @(posedge clk);
        #1;
        cfg_t = 0;
        smp_t = 0;
        repeat (5) @(posedge clk);
        #1;
        cfg_t = 1;
        smp_t = 1;
        repeat (5) @(posedge clk);
        #1;
        cfg_t = 0;
        smp_t = 0;
        wait_frames("sim_cnt", 1, 1000);
        repeat (300) @(posedge clk);
        check("sim_only_one", frames.size(), 1);
        if (frames.size() >= 1) begin
            check("sim_cs", frames[0].cs, 2'b10);
            check("sim_n", frames[0].nbits, 24);
        end
        check("sim_dv", dv_count - dv0, 1);

        frames.delete();
        @(posedge clk); #1;
        cfg_t = 1;
        repeat (60) @(posedge clk);
        @(negedge clk); #2;
        RESET = 0;
        #1;
        check("abort_csn", spi_csn, 2'b11);
        check("abort_sclk", spi_clk, 0);
        check("abort_mosi", spi_mosi, 0);
        check("abort_txdv", tx_dv, 0);
        check("abort_data", dut_data, 16'h0000);
        #10;
        RESET = 1;
        repeat (300) @(posedge clk);
        check("abort_frames", frames.size(), 1);
        if (frames.size() >= 1)
            check("abort_partial", frames[0].nbits < 24, 1);

        #1;
        cfg_t = 0;
        repeat (5) @(posedge clk);
        frames.delete();
        pulse(1, 0);
        wait_frames("rearm_cnt", 1, 1000);
        if (frames.size() >= 1)
            check("rearm_mosi", frames[0].bits, 24'h001400);
        repeat (20) @(posedge clk);

        check("stray_sclk", stray_clk, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ad9467_adc_if.md
AD9467_ADC_IF -- requirements
Module: ad9467_adc_if

Interface
REQ-001 SHALL have parameter SPI_DIV, default 4; spi_clk half-period in adc_clk_in_p cycles, legal range 2..255.
REQ-002 SHALL have parameter CFG_ADDR, default 13'h014; AD9467 register address written by the configuration frame.
REQ-003 SHALL have parameter CFG_DATA, default 8'h00; data byte written by the configuration frame.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: adc_clk_in_p is the only clock and RESET is the asynchronous active-low reset.
REQ-005 SHALL have the following ports (name, direction, width, meaning):
- adc_clk_in_p, in, 1: ADC data clock, also the SPI timebase.
- RESET, in, 1: asynchronous active-low reset.
- adc_data_in_p, in, 8: DDR data pins. Each pin carries two bits per cycle.
- data_reg_check, out, 16: reconstructed 16-bit sample.
- data_store_reg, out, 16: snapshot sample. Present only with DATA_STORE_OUT_EN.
- spi_clk, out, 1: SPI clock.
- spi_mosi, out, 1: SPI serial data out.
- spi_miso, in, 1: SPI serial data in.
- spi_send_trigger, in, 1: rising edge requests a sample frame.
- AD9467_spi_trigger, in, 1: rising edge requests a configuration frame.
- TX_DV_check, out, 1: one-cycle pulse at the start of each frame.
- spi_csn, out, 2: active-low chip selects. Bit 0 selects the AD9467; bit 1 selects the sample sink.

Function
REQ-006 SHALL sample adc_data_in_p[k] on each rising edge into odd bit 2k+1 and on each falling edge into even bit 2k.
REQ-007 SHALL update data_reg_check on every rising edge with the rise/fall pair captured over the previous cycle (1-cycle latency). A static 8'hAA input SHALL yield 16'hCCCC and a static 8'h55 SHALL yield 16'h3333.
REQ-008 SHALL detect rising edges of both triggers with a registered previous value. Trigger inputs that are X/Z SHALL NOT start a frame.
REQ-009 SHALL implement FSM IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
- In LOAD, TX_DV_check is high for exactly one cycle.
- DONE holds chip selects high for one spi_clk period before returning to IDLE.
REQ-010 Configuration frame SHALL be 24 bits, MSB first: {1'b0 (write), 2'b00 (one byte), CFG_ADDR, CFG_DATA}. spi_csn SHALL be 2'b10 for its duration.
REQ-011 Sample frame SHALL be 16 bits, MSB first, of the data_reg_check value captured in LOAD. spi_csn SHALL be 2'b01 for its duration.
REQ-012 SPI timing SHALL be mode 0:
- spi_clk idles low.
- spi_mosi changes on spi_clk falling edges, with the first bit valid on csn assertion.
- spi_miso is sampled on spi_clk rising edges into an internal receive register.
REQ-013 Triggers arriving while not in IDLE SHALL be ignored. Simultaneous edges in IDLE SHALL start the configuration frame and drop the sample request.
REQ-014 spi_clk SHALL toggle every SPI_DIV adc_clk_in_p cycles only in SHIFT. The number of spi_clk rising edges per frame SHALL equal the frame length exactly.

Reset
REQ-015 Asserting RESET (low) SHALL asynchronously force the following, aborting any frame in progress:
- data_reg_check = 0, data_store_reg = 0
- spi_clk = 0, spi_mosi = 0, spi_csn = 2'b11, TX_DV_check = 0
- FSM in IDLE, trigger edge registers = 0
REQ-016 After deassertion, a trigger held high SHALL NOT start a frame until it goes low and high again.

Configuration
REQ-017 With DATA_STORE_OUT_EN defined, SHALL expose port data_store_reg, loaded with the frame payload in LOAD of each sample frame.
REQ-018 Without DATA_STORE_OUT_EN, SHALL omit the port and its register. All other behaviour is unchanged.

Structure
REQ-019 Package ad9467_adc_if_pkg SHALL hold:
- FSM state enum
- CFG_FRAME_LEN = 24 and SAMPLE_FRAME_LEN = 16
- the chip-select encodings: CS_NONE = 2'b11, CS_ADC = 2'b10, CS_SINK = 2'b01
REQ-020 The SPI shifter/clock generator SHALL be sub-module ad9467_spi_master, with parallel load, length input and a done output. DDR capture stays in the top level.

Verification
REQ-021 Hold RESET low 10 ns, then release -> all outputs at reset values and spi_csn = 2'b11 throughout.
REQ-022 adc_data_in_p = 8'hAA held -> data_reg_check = 16'hCCCC one cycle later; change to 8'h55 -> 16'h3333.
REQ-023 Rising edge on AD9467_spi_trigger with default parameters -> TX_DV_check pulses once, spi_csn = 2'b10, 24 clocks, mosi = 24'h001400.
REQ-024 spi_send_trigger edge while data_reg_check = 16'hCCCC -> spi_csn = 2'b01, 16 clocks, mosi = 16'hCCCC, data_store_reg = 16'hCCCC (macro defined).
REQ-025 Both triggers rising in the same cycle, then a retrigger mid-frame -> exactly one 24-bit configuration frame and no sample frame.
REQ-026 RESET asserted mid-frame -> spi_csn = 2'b11 and spi_clk = 0 immediately; no frame resumes after release.
